sw_debounce: RTL

Conditions the raw mechanical slide switches before they reach the switch-to-target mapping logic. Each switch input passes through a two-flop synchronizer and a per-bit stability counter, so the downstream control logic only sees clean, glitch-free levels. The block also flags when the switch bank has settled after reset, and it emits a one-cycle strobe plus a bit mask whenever any debounced switch changes.

---
 rtl/sw_debounce.sv | 84 ++++++++
 1 files changed

// File: rtl/sw_debounce.sv
// Switch-bank conditioner: two-flop synchronizer, per-bit stability counter,
// settle flag after reset and a registered change strobe with bit mask.
module sw_debounce #(
  parameter int N               = 10,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] sw_raw,
  output logic [N-1:0] sw,
  output logic         sw_valid,
  output logic         changed,
  output logic [N-1:0] changed_mask
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int ST_W  = $clog2(DEBOUNCE_CYCLES + 3);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0]  ST_MAX  = ST_W'(DEBOUNCE_CYCLES + 2);

  logic [N-1:0]     s1_p0;
  logic [N-1:0]     s2_p1;
  logic [CNT_W-1:0] cnt [N];
  logic [N-1:0]     mis;
  logic [N-1:0]     upd;
  logic [N-1:0]     upd_p2;
  logic [ST_W-1:0]  st;

  function automatic logic [ST_W-1:0] st_sat_inc(input logic [ST_W-1:0] v);
    return (v == ST_MAX) ? v : v + ST_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] v,
                                                input logic m);
    if (!m || v == CNT_MAX) return '0;
    return v + CNT_W'(1);
  endfunction

  // Stage 0/1: metastability synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_p0 <= '0;
      s2_p1 <= '0;
    end else begin
      s1_p0 <= sw_raw;
      s2_p1 <= s1_p0;
    end
  end

  always_comb begin
    mis = s2_p1 ^ sw;
    upd = '0;
    for (int i = 0; i < N; i++) upd[i] = mis[i] && (cnt[i] == CNT_MAX);
  end

  // Stage 2: per-bit stability counters and debounced levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
      sw     <= '0;
      upd_p2 <= '0;
    end else begin
      for (int i = 0; i < N; i++) cnt[i] <= cnt_next(cnt[i], mis[i]);
      sw     <= (sw & ~upd) | (s2_p1 & upd);
      upd_p2 <= upd;
    end
  end

  // Stage 3: settle flag and change strobe; strobe trails the sw update by one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= '0;
      sw_valid     <= 1'b0;
      changed      <= 1'b0;
      changed_mask <= '0;
    end else begin
      st <= st_sat_inc(st);
      if (!sw_valid && st == ST_MAX && mis == '0 && upd == '0) sw_valid <= 1'b1;
      changed      <= sw_valid && (upd_p2 != '0);
      changed_mask <= sw_valid ? upd_p2 : '0;
    end
  end

endmodule
